// File: rtl/encoder_pkg.sv
// Shared definitions for the sequential priority encoder: FSM state type and
// bit-scan helpers that operate on a fixed maximum-width vector so they can be
// reused by blocks of any width up to MAX_DECODE_WIDTH (zero-extend on call).
package encoder_pkg;

    // Widest request vector the helpers cover (ENCODE_WIDTH up to 6).
    localparam int MAX_DECODE_WIDTH = 64;

    typedef logic [MAX_DECODE_WIDTH-1:0] wide_vec_t;

    // Two-state serving FSM.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lsb_index(input wide_vec_t v);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_DECODE_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_single_bit(input wide_vec_t v);
        return (v != '0) && ((v & (v - wide_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/priority_encoder_seq_lsb_encoder.sv
// Purely combinational lowest-set-bit to binary index converter.
// Returns 0 for an all-zero vector; callers qualify with their own valid.
module lsb_encoder
    import encoder_pkg::*;
#(
    parameter int ENCODE_WIDTH = 2,
    parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH
) (
    input  logic [DECODE_WIDTH-1:0] vec,
    output logic [ENCODE_WIDTH-1:0] idx
);

    wide_vec_t vec_wide;

    // Zero-extend to the helper width and scan for the lowest set bit.
    always_comb begin
        vec_wide = '0;
        vec_wide[DECODE_WIDTH-1:0] = vec;
        idx = ENCODE_WIDTH'(lsb_index(vec_wide));
    end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: accepts a (multi-)hot request vector over a
// valid/ready handshake and streams out the index of every set bit, lowest
// first, one per output transfer. All outputs are decoded from registered
// state only, so there is no combinational path from any input to any output.
module priority_encoder_seq
    import encoder_pkg::*;
#(
    parameter int ENCODE_WIDTH = 2,
    parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DECODE_WIDTH-1:0] in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ENCODE_WIDTH-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic [DECODE_WIDTH-1:0] pending;
    logic [DECODE_WIDTH-1:0] pending_nxt;
    logic [DECODE_WIDTH-1:0] lsb_onehot;
    logic [ENCODE_WIDTH-1:0] lsb_idx;
    wide_vec_t               pending_wide;

    lsb_encoder #(
        .ENCODE_WIDTH(ENCODE_WIDTH),
        .DECODE_WIDTH(DECODE_WIDTH)
    ) u_lsb_encoder (
        .vec(pending),
        .idx(lsb_idx)
    );

    // Decode handshake and index outputs from the registered state/pending.
    always_comb begin
        pending_wide = '0;
        pending_wide[DECODE_WIDTH-1:0] = pending;
        in_ready   = (state == IDLE);
        busy       = (state == SERVE);
        out_valid  = (state == SERVE);
        out        = (state == SERVE) ? lsb_idx : '0;
        out_last   = (state == SERVE) && is_single_bit(pending_wide);
        lsb_onehot = DECODE_WIDTH'(1) << lsb_idx;
    end

    // Next-state logic: load on accept, clear the served bit on transfer.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                // An all-zero vector is accepted but produces no beats.
                if (in_valid) begin
                    pending_nxt = in;
                    state_nxt   = (in != '0) ? SERVE : IDLE;
                end
            end
            SERVE: begin
                if (out_ready) begin
                    pending_nxt = pending & ~lsb_onehot;
                    state_nxt   = (pending_nxt == '0) ? IDLE : SERVE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    // State and pending register; reset drops any unserved bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq (ENCODE_WIDTH=2): directed cases plus random
// vectors, with a queue scoreboard fed by the driver and drained by a monitor.
module tb_priority_encoder_seq;

    localparam int EW = 2;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EW-1:0] out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beats {index, last} and accepted non-zero vectors.
    logic [EW:0]   exp_q[$];
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] recon = '0;

    logic          prev_stall = 1'b0;
    logic [EW:0]   prev_beat = '0;
    bit            rand_ready = 1'b0;
    bit            stop_rand = 1'b0;

    priority_encoder_seq #(.ENCODE_WIDTH(EW), .DECODE_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: every set bit in ascending order; last = no higher bits.
    task automatic model_push(input logic [DW-1:0] v);
        logic [DW-1:0] rest;
        for (int i = 0; i < DW; i++) begin
            if (v[i]) begin
                rest = v >> (i + 1);
                exp_q.push_back({EW'(i), (rest == '0)});
            end
        end
        if (v != '0) acc_q.push_back(v);
    endtask

    // Drive one vector until it is accepted; record expectations on accept.
    task automatic send(input logic [DW-1:0] v);
        bit taken;
        taken = 0;
        @(posedge clk); #1;
        in = v;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && !taken; c++) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(v);
                taken = 1;
            end
        end
        if (!taken) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in = '0;
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs checked without an edge.
    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        recon = '0;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare each transfer against the scoreboard, check status
    // decode, stall stability, and rebuild vectors through a one-hot decode.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check("serve_status", {30'd0, busy, in_ready}, {30'd0, 1'b1, 1'b0});
            end else begin
                check("idle_status", {27'd0, out, out_last, busy, in_ready},
                      {27'd0, 2'b00, 1'b0, 1'b0, 1'b1});
            end
            if (prev_stall) begin
                check("stall_hold", {29'd0, out_valid, out, out_last}, {29'd0, 1'b1, prev_beat});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {29'd0, out, out_last}, 32'hFFFF_FFFF);
                end else begin
                    check("beat", {29'd0, out, out_last}, {29'd0, exp_q.pop_front()});
                end
                recon = recon | (DW'(1) << out);
                if (out_last) begin
                    if (acc_q.size() == 0) begin
                        check("recon_extra", 32'(recon), 32'hFFFF_FFFF);
                    end else begin
                        check("recon_vector", 32'(recon), 32'(acc_q.pop_front()));
                    end
                    recon = '0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out, out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        // Case 1: reset with no clock edge needed.
        #2;
        pulse_reset();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Case 2: one-hot.
        out_ready = 1'b1;
        send(4'b0100);
        check("onehot_out", {29'd0, out_valid, out, out_last}, {29'd0, 1'b1, 2'b10, 1'b1});
        @(posedge clk); #1;
        check("onehot_done", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});

        // Case 3: multi-hot drains in three cycles.
        send(4'b1011);
        repeat (2) @(posedge clk);
        #1;
        check("multihot_last", {29'd0, out_valid, out, out_last}, {29'd0, 1'b1, 2'b11, 1'b1});
        @(posedge clk); #1;
        check("multihot_idle", 32'(in_ready), 32'd1);

        // Case 4: backpressure for three cycles.
        out_ready = 1'b0;
        send(4'b0110);
        repeat (3) begin
            check("bp_hold", {28'd0, out_valid, out, in_ready}, {28'd0, 1'b1, 2'b01, 1'b0});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Case 5: zero vector is swallowed.
        send(4'b0000);
        repeat (3) begin
            check("zero_quiet", {30'd0, out_valid, busy}, 32'd0);
            @(posedge clk); #1;
        end

        // Case 6: reset after the first transfer of 1111.
        send(4'b1111);
        @(posedge clk);
        pulse_reset();
        send(4'b1000);
        check("after_rst", {29'd0, out_valid, out, out_last}, {29'd0, 1'b1, 2'b11, 1'b1});
        repeat (2) @(posedge clk);
        #1;

        // Random vectors with random backpressure and input gaps.
        rand_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    send(DW'($urandom_range(0, 15)));
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;

        // Bounded drain.
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_vectors", 32'(acc_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
# priority_encoder_seq

Sequential inverse of the team's binary-to-one-hot decoder. Accepts a request vector (one-hot or multi-hot) over a valid/ready handshake and emits the binary index of every set bit, one per accepted output beat, lowest index first. Used wherever a bank of per-line flags, such as decoded select lines or pending-interrupt bits, must be turned back into a stream of encoded indices.

## Interface
Parameters:
- ENCODE_WIDTH, default 2: width of the encoded index; must be ≥ 1.
- DECODE_WIDTH, default 2**ENCODE_WIDTH: width of the request vector; must equal 2**ENCODE_WIDTH.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in  input  DECODE_WIDTH  request vector; bit i requests index i.
- in_valid  input  1  `in` is valid this cycle.
- in_ready  output  1  block can accept a vector.
- out  output  ENCODE_WIDTH  encoded index of the lowest pending bit; 0 when out_valid=0.
- out_valid  output  1  `out` holds a valid index.
- out_ready  input  1  consumer accepts `out` this cycle.
- out_last  output  1  current `out` is the final pending index of the vector.
- busy  output  1  vector is being served (state SERVE).

## Operation
- State: `pending` register [DECODE_WIDTH-1:0] plus a two-state FSM, IDLE and SERVE.
- IDLE: in_ready=1, out_valid=0. On in_valid & in_ready:
  - in ≠ 0: pending ← in, next state SERVE.
  - in = 0: accepted and discarded. pending stays 0, state stays IDLE, no output beat.
- SERVE: in_ready=0, busy=1, out_valid=1.
  - out = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
- Output transfer on out_valid & out_ready: clear bit `out` of pending.
  - If the result is 0, next state is IDLE.
  - Otherwise stay in SERVE and present the next lowest index the following cycle.
- Backpressure: while out_ready=0, out, out_last and pending hold stable.
- Inputs arriving while in SERVE are not accepted, since in_ready=0. The upstream must hold them.
- out, out_valid, out_last, busy and in_ready are decoded from the registered state and pending only. There are no combinational paths from in/in_valid/out_ready to any output.
- Reset (asynchronous, at any time, including mid-SERVE): pending=0, state IDLE.
  - Outputs immediately become out=0, out_valid=0, out_last=0, busy=0, in_ready=1.
  - Unserved bits are lost.

## Timing
- Accept at rising edge N yields out_valid=1 from edge N to edge N+1 (one-cycle latency).
- Throughput: one index per cycle while out_ready=1. A vector with k set bits drains in exactly k cycles.
- The final transfer at edge M returns the block to IDLE, with in_ready=1 after edge M. The next vector can be accepted at edge M+1, giving one bubble cycle between vectors.
- Inputs are sampled only at the clock edge.

## Structure
- Shared package `encoder_pkg`:
  - typedef enum for the FSM state (IDLE, SERVE).
  - Helper function `lsb_index` returning the lowest set-bit index.
  - Helper function `is_single_bit`.
- Sub-module `lsb_encoder` (parameterized by ENCODE_WIDTH): purely combinational lowest-set-bit to binary conversion. It is instantiated once on `pending` and is reusable elsewhere.
- Top level holds the FSM, the pending register and the handshake logic.

## Test plan
All cases use ENCODE_WIDTH=2.
1. Reset: assert rst asynchronously mid-cycle → out=0, out_valid=0, out_last=0, busy=0, in_ready=1 with no clock edge needed.
2. One-hot: in=4'b0100, in_valid=1 for one cycle, out_ready=1 → next cycle out=2'b10, out_valid=1, out_last=1; the cycle after, in_ready=1 and busy=0.
3. Multi-hot: in=4'b1011, out_ready=1 → out=0, 1, 3 on three consecutive cycles; out_last=1 only with 3; then IDLE.
4. Backpressure: in=4'b0110, out_ready=0 for 3 cycles → out=1 and out_valid=1 held stable and in_ready=0 throughout; then out_ready=1 → out=1, then out=2 with out_last=1.
5. Zero vector: in=4'b0000, in_valid=1 → accepted (in_ready stays 1), out_valid never rises, busy stays 0.
6. Reset mid-operation: in=4'b1111, reset after the first transfer (out=0) → out_valid=0 immediately; then in=4'b1000 → out=3 with out_last=1. A scoreboard feeding each `out` through the team decoder must reconstruct exactly the accepted vectors from cases 2-4.
